// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// WIDTH iterations per division, with a one-edge fast path for divide-by-zero.
module restoring_divider #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   rem, quo, divisor;
   logic [CNT_W-1:0]   cnt;
   logic               accept, last_iter;
   logic [WIDTH-1:0]   rem_sh, quo_sh, rem_nxt, quo_nxt;
   logic [WIDTH+1:0]   trial;
   logic               borrow;

   assign busy      = (state == RUN);
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic and start acceptance
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (b != '0) state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_iter) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One restoring iteration: shift, trial subtract, keep or restore.
   // After k iterations rem < 2^k, so the shifted remainder never needs an
   // extra bit before the final step; the borrow is read across both top
   // bits of the widened difference, which are equal whenever it is negative.
   always_comb begin
      rem_sh  = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_sh  = {quo[WIDTH-2:0], 1'b0};
      trial   = {2'b00, rem_sh} - {2'b00, divisor};
      borrow  = |trial[WIDTH+1:WIDTH];
      rem_nxt = borrow ? rem_sh : trial[WIDTH-1:0];
      quo_nxt = {quo_sh[WIDTH-1:1], ~borrow};
   end

   // Datapath registers and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem         <= '0;
         quo         <= '0;
         divisor     <= '0;
         cnt         <= '0;
         q           <= '0;
         r           <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            divisor     <= b;
            cnt         <= '0;
            div_by_zero <= (b == '0);
            rem         <= '0;
            quo         <= a;
            if (b == '0) begin
               q    <= '1;
               r    <= a;
               done <= 1'b1;
            end
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (last_iter) begin
               q    <= quo_nxt;
               r    <= rem_nxt;
               done <= 1'b1;
            end
         end
      end
   end

endmodule
